tdc_capture_decoder: RTL and testbench

//  Read side of the TDC delay line: launches the pulse into the line, samples
//  the N-tap thermometer word, and double-registers it for metastability.

---
 rtl/tdc_pkg.sv | 18 +
 rtl/tdc_therm2bin.sv | 46 ++++
 rtl/tdc_capture_decoder.sv | 105 ++++++++++
 tb/tb_tdc_capture_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC capture/decode path.
// The state enum and the code-width function are imported by the capture top and the encoder.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SAMPLE,
    ENCODE,
    OUT,
    RECOVER
  } tdc_cap_state_e;

  function automatic int tdc_code_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Thermometer-to-binary encoder: counts the consecutive ones from tap 0 up to the first zero.
// Optional macro TDC_BUBBLE_FIX_EN applies a 3-tap majority filter to the taps first.
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter int N      = 64,
  parameter int CODE_W = tdc_code_w(N)
) (
  input  logic [N-1:0]      therm,
  output logic [CODE_W-1:0] code
);

  logic [N-1:0] fixed;

`ifdef TDC_BUBBLE_FIX_EN
  // Pad so that tap -1 reads as 1 and tap N reads as 0; padded[k+1] is tap k.
  logic [N+1:0] padded;
  assign padded = {1'b0, therm, 1'b1};

  always_comb begin
    fixed = '0;
    for (int k = 0; k < N; k++) begin
      fixed[k] = (padded[k]   & padded[k+1]) |
                 (padded[k+1] & padded[k+2]) |
                 (padded[k]   & padded[k+2]);
    end
  end
`else
  assign fixed = therm;
`endif

  always_comb begin
    logic run;
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    code = '0;
    run  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (run && fixed[k]) begin
        code = CODE_W'(k + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdc_capture_decoder.sv
// TDC read side: launches the pulse, double-registers the tap word, and presents the decoded code on valid/ready.
// Build option: define TDC_BUBBLE_FIX_EN to enable bubble correction in tdc_therm2bin.
module tdc_capture_decoder
  import tdc_pkg::*;
#(
  parameter int N       = 64,
  parameter int CODE_W  = tdc_code_w(N),
  parameter int RECOVER = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              launch_o,
  input  logic [N-1:0]      therm_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovf_o,
  output logic              zero_o,
  output logic              busy_o
);

  localparam int                CNT_W    = (RECOVER > 1) ? $clog2(RECOVER) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = (RECOVER > 0) ? CNT_W'(RECOVER - 1) : '0;

  tdc_cap_state_e     state, state_next;
  logic [CNT_W-1:0]   rec_cnt, rec_cnt_next;
  logic [N-1:0]       cap1, cap2;
  logic [CODE_W-1:0]  enc_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rec_cnt <= '0;
    end else begin
      // NOTE: sequential state is updated with <= so every register samples pre-edge values.
      state   <= state_next;
      rec_cnt <= rec_cnt_next;
    end
  end

  // The RECOVER parameter shadows the imported enum literal, hence the qualified tdc_pkg::RECOVER.
  always_comb begin
    state_next   = state;
    rec_cnt_next = rec_cnt;
    case (state)
      IDLE:    if (start_i) state_next = LAUNCH;
      LAUNCH:  state_next = SAMPLE;
      SAMPLE:  state_next = ENCODE;
      ENCODE:  state_next = OUT;
      OUT: begin
        if (ready_i) begin
          if (RECOVER == 0) begin
            state_next = IDLE;
          end else begin
            state_next   = tdc_pkg::RECOVER;
            rec_cnt_next = CNT_LOAD;
          end
        end
      end
      tdc_pkg::RECOVER: begin
        if (rec_cnt == '0) state_next = IDLE;
        else               rec_cnt_next = rec_cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs: launch_o and valid_o drop asynchronously with reset.
  always_comb begin
    launch_o = 1'b0;
    valid_o  = 1'b0;
    busy_o   = 1'b0;
    launch_o = (state == LAUNCH);
    valid_o  = (state == OUT);
    busy_o   = (state != IDLE);
  end

  tdc_therm2bin #(
    .N      (N),
    .CODE_W (CODE_W)
  ) u_therm2bin (
    .therm (cap2),
    .code  (enc_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap1   <= '0;
      cap2   <= '0;
      code_o <= '0;
      ovf_o  <= 1'b0;
      zero_o <= 1'b0;
    end else begin
      if (state == LAUNCH) cap1 <= therm_i;
      if (state == SAMPLE) cap2 <= cap1;
      if (state == ENCODE) begin
        code_o <= enc_code;
        ovf_o  <= (enc_code == CODE_W'(N));
        zero_o <= (enc_code == '0);
      end
    end
  end

endmodule

// File: tb/tb_tdc_capture_decoder.sv
// Directed bench for tdc_capture_decoder (N=64, RECOVER=4); expectations are hand-computed.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_tdc_capture_decoder;

  localparam int N       = 64;
  localparam int CODE_W  = 7;
  localparam int RECOVER = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic              launch_o;
  logic [N-1:0]      therm_i;
  logic [CODE_W-1:0] code_o;
  logic              valid_o;
  logic              ready_i;
  logic              ovf_o;
  logic              zero_o;
  logic              busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  tdc_capture_decoder #(
    .N       (N),
    .CODE_W  (CODE_W),
    .RECOVER (RECOVER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .launch_o (launch_o),
    .therm_i  (therm_i),
    .code_o   (code_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .ovf_o    (ovf_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a measurement from IDLE and follow it to valid_o, checking the 3-edge latency.
  task automatic measure(input string tag, input logic [N-1:0] therm,
                         input int exp_code, input logic exp_ovf, input logic exp_zero);
    therm_i = therm;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, " launch E0"}, 64'(launch_o), 64'd1);
    check({tag, " valid E0"},  64'(valid_o),  64'd0);
    tick();
    check({tag, " launch E1"}, 64'(launch_o), 64'd0);
    tick();
    check({tag, " valid E2"},  64'(valid_o),  64'd0);
    tick();
    check({tag, " valid E3"},  64'(valid_o),  64'd1);
    check({tag, " code"},      64'(code_o),   64'(exp_code));
    check({tag, " ovf"},       64'(ovf_o),    64'(exp_ovf));
    check({tag, " zero"},      64'(zero_o),   64'(exp_zero));
  endtask

  // Accept the pending result, then walk the RECOVER window back to IDLE.
  task automatic accept_and_recover(input string tag);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, " valid after accept"}, 64'(valid_o), 64'd0);
    for (int i = 1; i < RECOVER; i++) begin
      tick();
      check({tag, " busy in recover"}, 64'(busy_o), 64'd1);
    end
    tick();
    check({tag, " idle after recover"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [CODE_W-1:0] held_code;
    int bubble_code;

    rst_n   = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b0;
    therm_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst launch", 64'(launch_o), 64'd0);
    check("rst valid",  64'(valid_o),  64'd0);
    check("rst code",   64'(code_o),   64'd0);
    check("rst ovf",    64'(ovf_o),    64'd0);
    check("rst zero",   64'(zero_o),   64'd0);
    check("rst busy",   64'(busy_o),   64'd0);
    rst_n = 1'b1;

    // ready_i with no pending result does nothing
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("idle ready busy",  64'(busy_o),  64'd0);
    check("idle ready valid", 64'(valid_o), 64'd0);

    // Reset mid-LAUNCH drops launch_o without waiting for a clock edge
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("pre-reset launch", 64'(launch_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async launch", 64'(launch_o), 64'd0);
    check("async busy",   64'(busy_o),   64'd0);
    check("async valid",  64'(valid_o),  64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // 24 consecutive ones
    measure("t24", 64'h0000_0000_00FF_FFFF, 24, 1'b0, 1'b0);
    accept_and_recover("t24");

    // All ones -> overflow; all zeros -> zero flag
    measure("ovf", '1, 64, 1'b1, 1'b0);
    accept_and_recover("ovf");
    measure("zero", '0, 0, 1'b0, 1'b1);
    accept_and_recover("zero");

    // Ones above the first zero are ignored (single-bit gaps are too wide apart for the majority filter)
    measure("gap", 64'hF0F0_0000_0000_0007, 3, 1'b0, 1'b0);
    accept_and_recover("gap");

    // Stall: output held, start_i ignored, busy asserted
    measure("stall", 64'h0000_0000_0000_0FFF, 12, 1'b0, 1'b0);
    held_code = code_o;
    therm_i   = '1;
    for (int i = 0; i < 10; i++) begin
      start_i = i[0];
      tick();
      check("stall valid", 64'(valid_o),  64'd1);
      check("stall code",  64'(code_o),   64'd12);
      check("stall busy",  64'(busy_o),   64'd1);
      check("stall launch", 64'(launch_o), 64'd0);
    end
    start_i = 1'b0;
    check("stall held", 64'(code_o), 64'(held_code));
    accept_and_recover("stall");

    // Bubble pattern 1101_1111
`ifdef TDC_BUBBLE_FIX_EN
    bubble_code = 8;
`else
    bubble_code = 5;
`endif
    measure("bubble", 64'h0000_0000_0000_00DF, bubble_code, 1'b0, 1'b0);
    accept_and_recover("bubble");

    // Back-to-back with start_i held high
    therm_i = 64'h0000_0000_0000_003F;
    start_i = 1'b1;
    tick();
    check("b2b launch1", 64'(launch_o), 64'd1);
    tick();
    therm_i = 64'h0000_0000_0000_03FF;
    check("b2b launch1 width", 64'(launch_o), 64'd0);
    tick();
    tick();
    check("b2b valid1", 64'(valid_o), 64'd1);
    check("b2b code1",  64'(code_o),  64'd6);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("b2b accept1", 64'(valid_o), 64'd0);
    for (int i = 1; i <= RECOVER; i++) begin
      tick();
      check("b2b no early launch", 64'(launch_o), 64'd0);
    end
    tick();
    check("b2b launch2 at R+1", 64'(launch_o), 64'd1);
    start_i = 1'b0;
    tick();
    tick();
    check("b2b no early valid2", 64'(valid_o), 64'd0);
    tick();
    check("b2b valid2", 64'(valid_o), 64'd1);
    check("b2b code2",  64'(code_o),  64'd10);
    accept_and_recover("b2b2");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("b2b no duplicate valid",  64'(valid_o),  64'd0);
      check("b2b no duplicate launch", 64'(launch_o), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
